// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Interrupt priority order, CSR addresses and mstatus field positions.
package trap_ctrl_pkg;

   localparam int RV_XLEN = 32;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   typedef enum logic [1:0] {
      IDLE,
      FLUSH,
      REDIRECT
   } trap_state_t;

   typedef enum logic [3:0] {
      IRQ_U_SW    = 4'd0,
      IRQ_S_SW    = 4'd1,
      IRQ_M_SW    = 4'd3,
      IRQ_U_TIMER = 4'd4,
      IRQ_S_TIMER = 4'd5,
      IRQ_M_TIMER = 4'd7,
      IRQ_U_EXT   = 4'd8,
      IRQ_S_EXT   = 4'd9,
      IRQ_M_EXT   = 4'd11
   } ex_cause_t;

   localparam int N_IRQ = 9;

   // Highest priority first.
   localparam ex_cause_t IRQ_PRIO [N_IRQ] = '{
      IRQ_M_EXT, IRQ_M_SW, IRQ_M_TIMER,
      IRQ_S_EXT, IRQ_S_SW, IRQ_S_TIMER,
      IRQ_U_EXT, IRQ_U_SW, IRQ_U_TIMER
   };

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   function automatic logic priv_legal(input logic [1:0] p);
      return (p == PRIV_LVL_U) || (p == PRIV_LVL_M);
   endfunction

endpackage

// File: rtl/trap_intr_arb.sv
// Fixed-priority interrupt selector with global-enable qualifier.
// Picks the highest-priority pending+enabled line from the priority table.
module trap_intr_arb
   import trap_ctrl_pkg::*;
(
   input  logic        [11:0] pend,
   input  logic               gate_en,
   output logic               take,
   output ex_cause_t          cause,
   output logic        [3:0]  code
);

   logic      hit;
   ex_cause_t sel;

   // Walk lowest to highest so the last match is the winner.
   always_comb begin
      hit = 1'b0;
      sel = IRQ_U_SW;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (pend[IRQ_PRIO[i]]) begin
            hit = 1'b1;
            sel = IRQ_PRIO[i];
         end
      end
   end

   assign take  = hit & gate_en;
   assign cause = sel;
   assign code  = sel;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller at the commit boundary.
// Owns trap CSRs and sequences flush then redirect for traps and mret.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int        XLEN       = RV_XLEN,
   parameter priv_lvl_t RESET_PRIV = PRIV_LVL_M
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_cause_i,
   input  logic [XLEN-1:0] ex_tval_i,
   input  logic [XLEN-1:0] commit_pc_i,
   input  logic            mret_i,
   input  logic [XLEN-1:0] mip_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic            flush_o,
   input  logic            flush_ack_i,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   input  logic            redirect_ready_i,
   output logic            busy_o,
   output logic [1:0]      priv_o,
   output logic            mstatus_mie_o,
   output logic            mstatus_mpie_o,
   output logic [1:0]      mstatus_mpp_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mcause_o,
   output logic [XLEN-1:0] mtval_o
);

   trap_state_t     state_q, state_d;
   priv_lvl_t       priv_q, mpp_q;
   logic            mie_q, mpie_q;
   logic [XLEN-1:0] mepc_q, mcause_q, mtval_q;
   logic [XLEN-1:0] tgt_q;

   logic [XLEN-1:0] pend_all;
   logic            irq_take;
   ex_cause_t       irq_cause;
   logic [3:0]      irq_code;
   logic            do_trap, do_mret, do_csr;
   logic [XLEN-1:0] trap_base, trap_tgt;
   logic [XLEN-1:0] irq_mcause;
   logic            unused_ok;

   assign pend_all = mip_i & mie_i;

   trap_intr_arb u_arb (
      .pend    (pend_all[11:0]),
      .gate_en ((priv_q == PRIV_LVL_U) | mie_q),
      .take    (irq_take),
      .cause   (irq_cause),
      .code    (irq_code)
   );

   assign unused_ok = ^{pend_all[XLEN-1:12], irq_cause};

   assign trap_base  = {mtvec_i[XLEN-1:2], 2'b00};
   assign irq_mcause = {1'b1, {(XLEN-5){1'b0}}, irq_code};

   // Vectored mode only offsets asynchronous causes.
   always_comb begin
      trap_tgt = trap_base;
      if (irq_take && mtvec_i[1:0] == 2'b01)
         trap_tgt = trap_base
                  + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
   end

   always_comb begin
      state_d          = state_q;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      busy_o           = 1'b0;
      do_trap          = 1'b0;
      do_mret          = 1'b0;
      do_csr           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (irq_take || ex_valid_i) begin
               do_trap = 1'b1;
               state_d = FLUSH;
            end else if (mret_i) begin
               do_mret = 1'b1;
               state_d = FLUSH;
            end else begin
               do_csr = csr_we_i;
            end
         end
         FLUSH: begin
            flush_o = 1'b1;
            busy_o  = 1'b1;
            if (flush_ack_i) state_d = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid_o = 1'b1;
            busy_o           = 1'b1;
            if (redirect_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         priv_q   <= RESET_PRIV;
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         mpp_q    <= PRIV_LVL_M;
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
         tgt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (do_trap) begin
            mepc_q   <= {commit_pc_i[XLEN-1:2], 2'b00};
            mcause_q <= irq_take ? irq_mcause : ex_cause_i;
            mtval_q  <= irq_take ? '0 : ex_tval_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            mpp_q    <= priv_q;
            priv_q   <= PRIV_LVL_M;
            tgt_q    <= trap_tgt;
         end else if (do_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
            priv_q <= mpp_q;
            mpp_q  <= PRIV_LVL_U;
            tgt_q  <= mepc_q;
         end else if (do_csr) begin
            unique case (1'b1)
               csr_addr_i == CSR_MSTATUS: begin
                  mie_q  <= csr_wdata_i[MSTATUS_MIE];
                  mpie_q <= csr_wdata_i[MSTATUS_MPIE];
                  if (priv_legal(csr_wdata_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]))
                     mpp_q <= priv_lvl_t'(
                        csr_wdata_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
               end
               csr_addr_i == CSR_MEPC:
                  mepc_q <= {csr_wdata_i[XLEN-1:2], 2'b00};
               csr_addr_i == CSR_MCAUSE: mcause_q <= csr_wdata_i;
               csr_addr_i == CSR_MTVAL:  mtval_q  <= csr_wdata_i;
               default: ;
            endcase
         end
      end
   end

   assign redirect_pc_o  = tgt_q;
   assign priv_o         = priv_q;
   assign mstatus_mie_o  = mie_q;
   assign mstatus_mpie_o = mpie_q;
   assign mstatus_mpp_o  = mpp_q;
   assign mepc_o         = mepc_q;
   assign mcause_o       = mcause_q;
   assign mtval_o        = mtval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomised bench for trap_ctrl against a behavioural trap model.
// Directed cases first, then random events with random handshake delays.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        ex_valid_i;
   logic [31:0] ex_cause_i, ex_tval_i, commit_pc_i;
   logic        mret_i;
   logic [31:0] mip_i, mie_i, mtvec_i;
   logic        csr_we_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        flush_o, flush_ack_i;
   logic        redirect_valid_o, redirect_ready_i;
   logic [31:0] redirect_pc_o;
   logic        busy_o;
   logic [1:0]  priv_o;
   logic        mstatus_mie_o, mstatus_mpie_o;
   logic [1:0]  mstatus_mpp_o;
   logic [31:0] mepc_o, mcause_o, mtval_o;

   int total = 0;
   int bad   = 0;

   logic [1:0]  m_priv, m_mpp;
   logic        m_mie, m_mpie;
   logic [31:0] m_mepc, m_mcause, m_mtval;

   trap_ctrl dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .ex_valid_i       (ex_valid_i),
      .ex_cause_i       (ex_cause_i),
      .ex_tval_i        (ex_tval_i),
      .commit_pc_i      (commit_pc_i),
      .mret_i           (mret_i),
      .mip_i            (mip_i),
      .mie_i            (mie_i),
      .mtvec_i          (mtvec_i),
      .csr_we_i         (csr_we_i),
      .csr_addr_i       (csr_addr_i),
      .csr_wdata_i      (csr_wdata_i),
      .flush_o          (flush_o),
      .flush_ack_i      (flush_ack_i),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .redirect_ready_i (redirect_ready_i),
      .busy_o           (busy_o),
      .priv_o           (priv_o),
      .mstatus_mie_o    (mstatus_mie_o),
      .mstatus_mpie_o   (mstatus_mpie_o),
      .mstatus_mpp_o    (mstatus_mpp_o),
      .mepc_o           (mepc_o),
      .mcause_o         (mcause_o),
      .mtval_o          (mtval_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_reset();
      m_priv   = 2'b11;
      m_mpp    = 2'b11;
      m_mie    = 1'b0;
      m_mpie   = 1'b0;
      m_mepc   = '0;
      m_mcause = '0;
      m_mtval  = '0;
   endtask

   task automatic chk_csr(input string tag);
      chk({tag, ".priv"},   priv_o,         m_priv);
      chk({tag, ".mie"},    mstatus_mie_o,  m_mie);
      chk({tag, ".mpie"},   mstatus_mpie_o, m_mpie);
      chk({tag, ".mpp"},    mstatus_mpp_o,  m_mpp);
      chk({tag, ".mepc"},   mepc_o,         m_mepc);
      chk({tag, ".mcause"}, mcause_o,       m_mcause);
      chk({tag, ".mtval"},  mtval_o,        m_mtval);
   endtask

   task automatic clear_in();
      ex_valid_i       = 0;
      ex_cause_i       = 0;
      ex_tval_i        = 0;
      commit_pc_i      = 0;
      mret_i           = 0;
      mip_i            = 0;
      mie_i            = 0;
      csr_we_i         = 0;
      csr_addr_i       = 0;
      csr_wdata_i      = 0;
      flush_ack_i      = 0;
      redirect_ready_i = 0;
   endtask

   // Noise that a busy controller must ignore.
   task automatic junk();
      ex_valid_i  = 1'($urandom);
      ex_cause_i  = 32'($urandom_range(0, 15));
      commit_pc_i = $urandom;
      mret_i      = 1'($urandom);
      mip_i       = $urandom;
      mie_i       = $urandom;
      csr_we_i    = 1'($urandom);
      csr_addr_i  = 12'h300 + 12'($urandom_range(0, 1) * 'h41);
      csr_wdata_i = $urandom;
   endtask

   // One IDLE-cycle event; model decides outcome, then handshakes.
   task automatic ev(input string tag,
                     input logic ex, input logic [31:0] cause,
                     input logic [31:0] tval, input logic [31:0] pc,
                     input logic mr,
                     input logic [31:0] ip, input logic [31:0] ie,
                     input logic [31:0] tvec,
                     input logic we, input logic [11:0] addr,
                     input logic [31:0] wd,
                     input int ack_dly, input int rdy_dly);
      int          prio [9] = '{11, 3, 7, 9, 1, 5, 8, 0, 4};
      logic [31:0] pend, tgt;
      bit          found, irq, go;
      int          code;
      ex_valid_i  = ex;
      ex_cause_i  = cause;
      ex_tval_i   = tval;
      commit_pc_i = pc;
      mret_i      = mr;
      mip_i       = ip;
      mie_i       = ie;
      mtvec_i     = tvec;
      csr_we_i    = we;
      csr_addr_i  = addr;
      csr_wdata_i = wd;
      pend  = ip & ie & 32'h0000_0BBB;
      found = 0;
      code  = 0;
      for (int i = 0; i < 9; i++)
         if (!found && pend[prio[i]]) begin
            found = 1;
            code  = prio[i];
         end
      irq = found && (m_priv == 2'b00 || m_mie);
      go  = 0;
      tgt = 0;
      if (irq || ex) begin
         go       = 1;
         m_mepc   = pc & ~32'h3;
         m_mcause = irq ? (32'h8000_0000 | code) : cause;
         m_mtval  = irq ? 32'h0 : tval;
         m_mpie   = m_mie;
         m_mie    = 0;
         m_mpp    = m_priv;
         m_priv   = 2'b11;
         tgt      = tvec & ~32'h3;
         if (irq && tvec[1:0] == 2'b01) tgt = tgt + 4 * code;
      end else if (mr) begin
         go     = 1;
         m_mie  = m_mpie;
         m_mpie = 1;
         m_priv = m_mpp;
         m_mpp  = 2'b00;
         tgt    = m_mepc;
      end else if (we) begin
         case (addr)
            12'h300: begin
               m_mie  = wd[3];
               m_mpie = wd[7];
               if (wd[12:11] == 2'b00 || wd[12:11] == 2'b11)
                  m_mpp = wd[12:11];
            end
            12'h341: m_mepc   = wd & ~32'h3;
            12'h342: m_mcause = wd;
            12'h343: m_mtval  = wd;
            default: ;
         endcase
      end
      step();
      clear_in();
      if (go) begin
         chk({tag, ".flush"}, flush_o, 1);
         chk({tag, ".busy"}, busy_o, 1);
         chk_csr(tag);
         repeat (ack_dly) begin
            junk();
            step();
            chk({tag, ".flush_hold"}, flush_o, 1);
            chk({tag, ".rv_early"}, redirect_valid_o, 0);
         end
         junk();
         flush_ack_i = 1;
         step();
         flush_ack_i = 0;
         chk({tag, ".rv"}, redirect_valid_o, 1);
         chk({tag, ".flush_drop"}, flush_o, 0);
         chk({tag, ".tgt"}, redirect_pc_o, tgt);
         repeat (rdy_dly) begin
            junk();
            step();
            chk({tag, ".rv_hold"}, redirect_valid_o, 1);
            chk({tag, ".tgt_hold"}, redirect_pc_o, tgt);
         end
         junk();
         redirect_ready_i = 1;
         step();
         clear_in();
         chk({tag, ".done_busy"}, busy_o, 0);
         chk({tag, ".done_rv"}, redirect_valid_o, 0);
         chk_csr({tag, ".done"});
      end else begin
         chk({tag, ".nobusy"}, busy_o, 0);
         chk({tag, ".noflush"}, flush_o, 0);
         chk_csr(tag);
      end
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      ev("csr", 0, 0, 0, 0, 0, 0, 0, mtvec_i, 1, a, d, 0, 0);
   endtask

   initial begin
      logic [11:0] addrs [5] = '{12'h300, 12'h341, 12'h342,
                                 12'h343, 12'h7c0};
      clear_in();
      mtvec_i = 0;
      rst_i   = 1;
      m_reset();
      step();
      step();
      rst_i = 0;
      chk("rst.flush", flush_o, 0);
      chk("rst.rv", redirect_valid_o, 0);
      chk("rst.busy", busy_o, 0);
      chk_csr("rst");
      repeat (10) begin
         step();
         chk("idle.flush", flush_o, 0);
      end

      csr_wr(12'h300, 32'h0000_1808);
      ev("exc", 1, 2, 32'hDEAD, 32'h8000_0104, 0, 0, 0,
         32'h8000_0000, 0, 0, 0, 0, 3);
      chk("exc.mcause", mcause_o, 2);
      chk("exc.mepc", mepc_o, 32'h8000_0104);
      chk("exc.mpie", mstatus_mpie_o, 1);

      csr_wr(12'h300, 32'h0000_1808);
      ev("vec", 0, 0, 0, 32'h8000_0200, 0, 32'h880, 32'h880,
         32'h8000_0001, 0, 0, 0, 1, 0);
      chk("vec.mcause", mcause_o, 32'h8000_000B);

      csr_wr(12'h300, 32'h0);
      ev("gate_m", 0, 0, 0, 32'h40, 0, 32'h80, 32'h80,
         32'h8000_0000, 0, 0, 0, 0, 0);
      ev("to_u", 0, 0, 0, 0, 1, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
      chk("to_u.priv", priv_o, 0);
      ev("gate_u", 0, 0, 0, 32'h44, 0, 32'h80, 32'h80,
         32'h8000_0000, 0, 0, 0, 0, 1);
      chk("gate_u.mpp", mstatus_mpp_o, 0);
      chk("gate_u.mcause", mcause_o, 32'h8000_0007);

      csr_wr(12'h341, 32'h100);
      csr_wr(12'h300, 32'h0000_0080);
      ev("mret", 0, 0, 0, 0, 1, 0, 0, 32'h8000_0000, 0, 0, 0, 2, 1);
      chk("mret.priv", priv_o, 0);
      chk("mret.mie", mstatus_mie_o, 1);

      ev("combo", 1, 5, 32'h1234, 32'h2002, 1, 0, 0,
         32'h8000_0000, 1, 12'h341, 32'h5555, 0, 0);
      chk("combo.mepc", mepc_o, 32'h2000);

      ex_valid_i  = 1;
      ex_cause_i  = 7;
      commit_pc_i = 32'h300;
      step();
      clear_in();
      chk("rstf.flush", flush_o, 1);
      rst_i = 1;
      step();
      rst_i = 0;
      m_reset();
      chk("rstf.flush0", flush_o, 0);
      chk("rstf.busy0", busy_o, 0);
      chk_csr("rstf");

      for (int n = 0; n < 300; n++) begin
         logic [31:0] ip, ie;
         ip = ($urandom_range(0, 1) == 0) ? 0 : ($urandom & $urandom);
         ie = $urandom & $urandom;
         ev("rnd", ($urandom_range(0, 3) == 0),
            32'($urandom_range(0, 15)), $urandom, $urandom,
            ($urandom_range(0, 4) == 0), ip, ie,
            ($urandom & ~32'h2),
            ($urandom_range(0, 1) == 1),
            addrs[$urandom_range(0, 4)], $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
